// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a 5-stage RISC-V pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             res,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             Branch_MEM,
  input  logic             zero_MEM,
  input  logic             MemRead_MEM,
  input  logic             MemWrite_MEM,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PC_write,
  output logic             PC_src,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             mem_stall, br_take, load_use, hazard, err_set;

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_set      = 1'b0;
    mem_req      = 1'b0;
    PC_write     = 1'b1;
    PC_src       = 1'b0;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    mem_stall    = 1'b0;
    br_take      = 1'b0;
    load_use     = 1'b0;
    hazard       = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                   ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    if (res) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (state == ERR) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end else begin
      mem_req   = MemRead_MEM | MemWrite_MEM;
      mem_stall = !mem_ready && ((state == MEM_WAIT) || mem_req);
      br_take   = !mem_stall && (state == RUN) && Branch_MEM && zero_MEM;
      load_use  = !mem_stall && !br_take && hazard;

      if (mem_stall) begin
        // Hold everything up to EX/MEM; WB receives a bubble each waiting cycle.
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_flush = 1'b1;
        if (state == RUN) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = CNT_W'(1);
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
          err_set   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end else begin
        state_nxt = RUN;
        wait_nxt  = '0;
        if (br_take) begin
          PC_src       = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
        end else if (load_use) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if ((mem_stall || load_use) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (br_take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
      if (err_set)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks of pipeline_hazard_ctrl against a rule model
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic res, Branch_MEM, zero_MEM, MemRead_MEM, MemWrite_MEM, mem_ready, ID_EX_MemRead;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic mem_req, PC_write, PC_src, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state: plain integers and flags
  bit m_waiting, m_err;
  int m_waited, m_stalls, m_flushes;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .res(res), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .Branch_MEM(Branch_MEM), .zero_MEM(zero_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .mem_ready(mem_ready),
    .mem_req(mem_req), .PC_write(PC_write), .PC_src(PC_src), .IF_ID_write(IF_ID_write),
    .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .MEM_WB_flush(MEM_WB_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {mem_req, PC_write, PC_src, IF_ID_w, ID_EX_w, EX_MEM_w, MEM_WB_w, IF_ID_f, ID_EX_f, EX_MEM_f, MEM_WB_f}
  function automatic logic [10:0] ctrl_vec();
    return {mem_req, PC_write, PC_src, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
            IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};
  endfunction

  function automatic bit m_memstall();
    bit req = MemRead_MEM | MemWrite_MEM;
    return !res && !m_err && !mem_ready && (m_waiting || req);
  endfunction

  function automatic bit m_branch();
    return !res && !m_err && !m_memstall() && !m_waiting && Branch_MEM && zero_MEM;
  endfunction

  function automatic bit m_loaduse();
    bit dep = ID_EX_MemRead && ID_EX_rd != 0 && (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
    return !res && !m_err && !m_memstall() && !m_branch() && dep;
  endfunction

  function automatic logic [10:0] m_ctrl();
    logic req = MemRead_MEM | MemWrite_MEM;
    if (res)          return 11'b0_0_0_0000_1111;
    if (m_err)        return 11'b0_0_0_0000_0001;
    if (m_memstall()) return {req, 10'b0_0_0001_0001};
    if (m_branch())   return {req, 10'b1_1_1111_1110};
    if (m_loaduse())  return {req, 10'b0_0_0111_0100};
    return {req, 10'b1_0_1111_0000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic br, input logic z, input logic mr, input logic mw,
                        input logic rdy, input logic idmr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    res = r; Branch_MEM = br; zero_MEM = z; MemRead_MEM = mr; MemWrite_MEM = mw;
    mem_ready = rdy; ID_EX_MemRead = idmr; ID_EX_rd = rd; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2;
  endtask

  // Checks combinational controls mid-cycle, then advances the model and checks registered state.
  task automatic cycle();
    bit ms, bt, lu;
    @(negedge clk);
    check("ctrl", 32'(ctrl_vec()), 32'(m_ctrl()));
    ms = m_memstall(); bt = m_branch(); lu = m_loaduse();
    @(posedge clk);
    if (res) begin
      m_waiting = 0; m_err = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_err) begin
      if (ms || lu) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
      if (bt) m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
      if (ms) begin
        if (!m_waiting) begin
          m_waiting = 1; m_waited = 1;
        end else if (m_waited == TO) begin
          m_err = 1; m_waiting = 0;
        end else begin
          m_waited++;
        end
      end else begin
        m_waiting = 0; m_waited = 0;
      end
    end
    #1;
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    check("mem_err", 32'(mem_err), 32'(m_err));
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // reset held two cycles
    cycle(); cycle();
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_flush", 32'(flush_cnt), 0);
    idle(); cycle();
    // load-use on rs2, then the same with x0 as destination
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5); cycle();
    check("lu_stall", 32'(stall_cnt), 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0); cycle();
    check("x0_nostall", 32'(stall_cnt), 1);
    // taken branch overrides load-use
    set_in(0, 1, 1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2); cycle();
    check("br_flush", 32'(flush_cnt), 1);
    check("br_nostall", 32'(stall_cnt), 1);
    // load waits three cycles, completes on the fourth
    repeat (3) begin set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle(); end
    set_in(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); cycle();
    check("wait_stall", 32'(stall_cnt), 4);
    // zero-wait access and ready on the timeout cycle both finish normally
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
    repeat (4) begin set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cycle(); end
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
    check("late_ready_noerr", 32'(mem_err), 0);
    // store times out after five waiting cycles, ERR is sticky
    repeat (5) begin set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cycle(); end
    check("timeout_err", 32'(mem_err), 1);
    set_in(0, 1, 1, 0, 1, 1, 1, 5'd3, 5'd3, 5'd3); cycle(); cycle();
    check("err_sticky", 32'(mem_err), 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("err_cleared", 32'(mem_err), 0);
    // reset in the middle of a wait
    repeat (2) begin set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle(); end
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); cycle();
    check("midwait_rst", 32'(stall_cnt), 0);
    // counter saturation
    repeat (SAT + 3) begin set_in(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0); cycle(); end
    check("stall_sat", 32'(stall_cnt), SAT);
    repeat (SAT + 3) begin set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle(); end
    check("flush_sat", 32'(flush_cnt), SAT);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    // random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 59) == 0), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory wait states using a req/ready handshake with timeout.
- Keeps stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 64, max wait cycles for mem_ready before declaring an error (legal range 1..2^CNT_W-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- res  input  1  synchronous reset, active-high.
- IF_ID_rs1  input  5  rs1 of the instruction in ID.
- IF_ID_rs2  input  5  rs2 of the instruction in ID.
- ID_EX_rd  input  5  rd of the instruction in EX.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- Branch_MEM  input  1  branch instruction in MEM.
- zero_MEM  input  1  ALU zero flag of the instruction in MEM.
- MemRead_MEM  input  1  load in MEM.
- MemWrite_MEM  input  1  store in MEM.
- mem_ready  input  1  data memory completes the access this cycle.
- mem_req  output  1  data memory access request.
- PC_write  output  1  PC load enable.
- PC_src  output  1  1 = PC loads the branch target.
- IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  output  1 each  register load enables.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  output  1 each  register loads a bubble (all control bits 0).
- mem_err  output  1  sticky memory timeout flag.
- stall_cnt  output  CNT_W  count of stall cycles.
- flush_cnt  output  CNT_W  count of branch flush events.

Behaviour:
- Reset:
  - With res=1 at a rising edge: state goes to RUN; wait_cnt, stall_cnt and flush_cnt go to 0; mem_err goes to 0.
  - While res=1, outputs are forced: all *_write=0, all *_flush=1, mem_req=0, PC_src=0.
  - A reset asserted mid-wait aborts the wait immediately.
- Control outputs are combinational from state and inputs. Counters and mem_err are registered.
- Default in RUN with no hazard: all *_write=1, all *_flush=0, PC_src=0.
- FSM states: RUN, MEM_WAIT, ERR.
- mem_req = (MemRead_MEM | MemWrite_MEM) in RUN and MEM_WAIT; 0 in ERR.
- Memory stall (highest priority):
  - Condition: in RUN with mem_req=1 and mem_ready=0, or in MEM_WAIT with mem_ready=0.
  - Outputs: PC and IF/ID/ID-EX/EX-MEM write=0 (hold); MEM_WB_write=1 with MEM_WB_flush=1 (bubble into WB); stall_cnt +1.
  - RUN -> MEM_WAIT, with wait_cnt=1.
  - In MEM_WAIT, wait_cnt increments each cycle.
- mem_ready=1 in RUN or MEM_WAIT: normal advance this cycle; MEM_WAIT -> RUN; wait_cnt cleared.
  - A zero-wait access (ready in the same cycle as the request) causes no stall.
- Timeout:
  - In MEM_WAIT with mem_ready=0 and wait_cnt==MEM_TIMEOUT: go to ERR and set mem_err=1.
  - ERR freezes all *_write=0, asserts MEM_WB_flush=1, and is left only by res.
  - stall_cnt does not count in ERR.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no error.
- Branch taken:
  - Condition: Branch_MEM & zero_MEM, no memory stall, state RUN.
  - Outputs: PC_src=1, PC_write=1; IF_ID_flush, ID_EX_flush and EX_MEM_flush=1 (write=1); flush_cnt +1.
  - The load-use stall is suppressed in the same cycle (the younger instructions are squashed).
- Load-use:
  - Condition: ID_EX_MemRead=1, ID_EX_rd!=0, and ID_EX_rd equals IF_ID_rs1 or IF_ID_rs2; no memory stall; no taken branch.
  - Outputs: PC_write=0, IF_ID_write=0, ID_EX_flush=1; EX_MEM and MEM_WB advance; stall_cnt +1.
  - Exactly one stall cycle per hazard (the next cycle sees the bubble in EX).
- Priority: reset > ERR > memory stall > branch flush > load-use > normal.
- Counters saturate at all-ones (no wrap).
- x0 is never a hazard.

Test Plan:
- Hold res=1 for 2 cycles -> all writes 0, flushes 1, mem_req 0, stall_cnt=0, flush_cnt=0, mem_err=0; release -> all writes 1, flushes 0.
- ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 for one cycle -> PC_write=0, IF_ID_write=0, ID_EX_flush=1, stall_cnt=1; repeat with ID_EX_rd=0 -> no stall.
- Branch_MEM=1, zero_MEM=1 while load-use condition is also true -> PC_src=1, IF_ID/ID_EX/EX_MEM flush=1, no stall, flush_cnt=1.
- MemRead_MEM=1, mem_ready low for 3 cycles then high -> mem_req=1 throughout, 3 cycles of freeze with MEM_WB_flush=1, advance on 4th cycle, stall_cnt=3, state back to RUN.
- MEM_TIMEOUT=4, MemWrite_MEM=1, mem_ready held 0 -> mem_err=1 after 5th cycle, pipeline frozen, mem_req=0; mem_ready later -> still ERR; res -> RUN, mem_err=0.
- Assert res during MEM_WAIT at wait_cnt=2 -> next cycle RUN, counters 0, no mem_err.
